// File: rtl/framebuffer_fill_if.sv
// framebuffer_fill_if: Avalon-MM write-only master bus used by the fill engine.
interface framebuffer_fill_if;
  logic [31:0] address;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        write;
  logic        waitrequest;
  modport master(output address, writedata, byteenable, write, input waitrequest);
  modport slave(input address, writedata, byteenable, write, output waitrequest);
endinterface

// File: rtl/framebuffer_fill.sv
// framebuffer_fill: walks a WIDTH x HEIGHT pixel buffer writing one RGB565 colour per pixel over Avalon-MM.
module framebuffer_fill #(
  parameter int WIDTH   = 320,
  parameter int HEIGHT  = 240,
  parameter int X_SHIFT = 1,
  parameter int Y_SHIFT = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [31:0] base_addr_i,
  input  logic [15:0] color_i,
  output logic        busy_o,
  output logic        done_o,
  framebuffer_fill_if.master m
);
  localparam int XW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam int YW = HEIGHT > 1 ? $clog2(HEIGHT) : 1;
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
  state_t      state_q;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [31:0] base_q, addr_q, addr_d, data_q;
  logic [3:0]  be_q;
  logic        write_q, busy_q, done_q, abort_q, last_x, stop;
  always_comb begin
    last_x = x_q == XW'(WIDTH - 1);
    x_d    = last_x ? '0 : x_q + XW'(1);
    y_d    = last_x ? y_q + YW'(1) : y_q;
    stop   = (last_x && y_q == YW'(HEIGHT - 1)) || abort_q || abort_i;
    addr_d = base_q + (32'(y_d) << Y_SHIFT) + (32'(x_d) << X_SHIFT);
  end
  // Outputs only change on acceptance, so a stalled write stays stable even across abort.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
      write_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          state_q <= WRITE;
          base_q  <= base_addr_i;
          addr_q  <= base_addr_i;
          be_q    <= base_addr_i[1] ? 4'b1100 : 4'b0011;
          data_q  <= {color_i, color_i};
          x_q     <= '0;
          y_q     <= '0;
          write_q <= 1'b1;
          busy_q  <= 1'b1;
          abort_q <= 1'b0;
        end
        WRITE: begin
          abort_q <= abort_q | abort_i;
          if (!m.waitrequest) begin
            if (stop) begin
              state_q <= DONE;
              write_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              x_q    <= x_d;
              y_q    <= y_d;
              addr_q <= addr_d;
              be_q   <= addr_d[1] ? 4'b1100 : 4'b0011;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          abort_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign m.address    = addr_q;
  assign m.writedata  = data_q;
  assign m.byteenable = be_q;
  assign m.write      = write_q;
endmodule

// File: tb/tb_framebuffer_fill.sv
// tb_framebuffer_fill: table-driven small-frame scenarios plus a randomized full-frame fill.
module tb_framebuffer_fill;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic s_start = 1'b0, s_abort = 1'b0, s_busy, s_done;
  logic [31:0] s_base = '0;
  logic [15:0] s_color = '0;
  logic b_start = 1'b0, b_abort = 1'b0, b_busy, b_done;
  logic [31:0] b_base = '0;
  logic [15:0] b_color = '0;
  int tests = 0, fails = 0;
  framebuffer_fill_if s_if();
  framebuffer_fill_if b_if();
  framebuffer_fill #(.WIDTH(4), .HEIGHT(3)) dut_s (
    .clock(clock), .reset(reset), .start_i(s_start), .abort_i(s_abort),
    .base_addr_i(s_base), .color_i(s_color), .busy_o(s_busy), .done_o(s_done), .m(s_if));
  framebuffer_fill dut_b (
    .clock(clock), .reset(reset), .start_i(b_start), .abort_i(b_abort),
    .base_addr_i(b_base), .color_i(b_color), .busy_o(b_busy), .done_o(b_done), .m(b_if));
  always #5 clock = ~clock;
  typedef struct {
    logic [31:0] base;
    logic [15:0] color;
    int stall_at, stall_len, abort_at, restart_at;
    int exp_writes, exp_done;
  } vec_t;
  vec_t vecs[6];
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask
  task automatic run_vec(input vec_t v);
    int acc = 0, stall = 0, lat = 0;
    logic [31:0] held = '0, ea;
    @(negedge clock);
    s_start = 1'b1; s_base = v.base; s_color = v.color;
    @(negedge clock);
    s_base = 32'hA5A5_0000; s_color = 16'h5A5A;
    for (int k = 1; k <= 200 && lat == 0; k++) begin
      if (k > 1) @(negedge clock);
      s_abort = 1'b0;
      if (s_done) begin
        lat = k;
        s_start = 1'b1; s_base = 32'hBEEF_0000;
      end else begin
        s_start = (k == v.restart_at);
        if (s_start) begin s_base = 32'hDEAD_0000; s_color = 16'h1234; end
        if (k == 2) chk("busy_during_fill", 64'(s_busy), 64'd1);
        s_if.waitrequest = s_if.write && acc == v.stall_at && stall < v.stall_len;
        if (s_if.waitrequest) begin
          if (stall == 0) held = s_if.address;
          else chk("stall_addr_hold", 64'(s_if.address), 64'(held));
          if (stall == 0 && acc == v.abort_at) s_abort = 1'b1;
          stall++;
        end else if (s_if.write) begin
          if (acc == v.stall_at && stall > 0) chk("stall_addr_release", 64'(s_if.address), 64'(held));
          ea = v.base + 32'((acc / 4) * 1024 + (acc % 4) * 2);
          chk("addr", 64'(s_if.address), 64'(ea));
          chk("data", 64'(s_if.writedata), 64'({v.color, v.color}));
          chk("byteenable", 64'(s_if.byteenable), ea[1] ? 64'hC : 64'h3);
          acc++;
        end
      end
    end
    if (lat == 0) chk("done_timeout", 64'd0, 64'd1);
    chk("done_latency", 64'(lat), 64'(v.exp_done));
    chk("write_count", 64'(acc), 64'(v.exp_writes));
    @(negedge clock);
    s_start = 1'b0;
    s_if.waitrequest = 1'b0;
    chk("after_done_state", 64'({s_done, s_busy, s_if.write}), 64'd0);
    @(negedge clock);
    chk("start_in_done_ignored", 64'({s_busy, s_if.write}), 64'd0);
  endtask
  task automatic run_big();
    int n = 0, errs = 0, reps = 0;
    bit seen [131072];
    logic [31:0] last = '0, off, ea;
    bit fin = 0;
    @(negedge clock);
    b_start = 1'b1; b_base = 32'h0800_0000; b_color = 16'h07FF;
    @(negedge clock);
    b_start = 1'b0; b_base = '0;
    for (int k = 0; k < 95000 && !fin; k++) begin
      if (k > 0) @(negedge clock);
      if (b_done) fin = 1;
      else begin
        b_if.waitrequest = ($urandom_range(0, 31) == 0);
        if (b_if.write && !b_if.waitrequest) begin
          ea = 32'h0800_0000 + 32'((n / 320) * 1024 + (n % 320) * 2);
          if (b_if.address !== ea || b_if.writedata !== 32'h07FF_07FF) errs++;
          off = b_if.address - 32'h0800_0000;
          if (off < 32'h0004_0000) begin
            if (seen[off[17:1]]) reps++;
            seen[off[17:1]] = 1'b1;
          end else reps++;
          last = b_if.address;
          n++;
        end
      end
    end
    b_if.waitrequest = 1'b0;
    chk("big_done_seen", 64'(fin), 64'd1);
    chk("big_write_count", 64'(n), 64'd76800);
    chk("big_sequence_errors", 64'(errs), 64'd0);
    chk("big_repeated_addr", 64'(reps), 64'd0);
    chk("big_last_addr", 64'(last), 64'h0803_BE7E);
  endtask
  initial begin
    vecs[0] = '{32'h0800_0000, 16'hF800, -1, 0, -1, 0, 12, 13};
    vecs[1] = '{32'h0800_0000, 16'hF800,  4, 3, -1, 0, 12, 16};
    vecs[2] = '{32'h0800_0000, 16'hF800,  1, 2,  1, 0,  2,  5};
    vecs[3] = '{32'h1234_5672, 16'h07E0, 11, 1, -1, 0, 12, 14};
    vecs[4] = '{32'hFFFF_FF00, 16'h001F, -1, 0, -1, 0, 12, 13};
    vecs[5] = '{32'h0800_0000, 16'hF800, -1, 0, -1, 3, 12, 13};
    s_if.waitrequest = 1'b0;
    b_if.waitrequest = 1'b0;
    @(negedge clock);
    chk("reset_ctrl", 64'({s_busy, s_done, s_if.write, b_busy, b_done, b_if.write}), 64'd0);
    chk("reset_addr", 64'(s_if.address), 64'd0);
    chk("reset_data", 64'(s_if.writedata), 64'd0);
    chk("reset_be", 64'(s_if.byteenable), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);
    @(negedge clock);
    s_start = 1'b1; s_base = 32'h0800_0000; s_color = 16'hF800;
    @(negedge clock);
    s_start = 1'b0;
    repeat (4) @(negedge clock);
    chk("pre_reset_writing", 64'(s_if.write), 64'd1);
    reset = 1'b1;
    #1;
    chk("async_reset_ctrl", 64'({s_if.write, s_busy, s_done}), 64'd0);
    chk("async_reset_addr", 64'(s_if.address), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    chk("reset_no_done", 64'(s_done), 64'd0);
    run_vec('{32'h0804_0000, 16'hF800, -1, 0, -1, 0, 12, 13});
    run_big();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/framebuffer_fill.md
# framebuffer_fill

Avalon-MM master engine that fills one pixel buffer with a single 16-bit colour. It sits downstream of the GPU's buffer-address registers and takes a buffer base address plus a colour. It then walks every pixel of a WIDTH×HEIGHT frame and writes the colour to SDRAM using DE1-SoC pixel-buffer addressing. It is used to clear the back buffer before voxel rendering and drives the GPU's m1 master port.

## Interface
- WIDTH, 320: pixels per row.
- HEIGHT, 240: rows per frame.
- X_SHIFT, 1: byte-address shift applied to x (2 bytes per pixel).
- Y_SHIFT, 10: byte-address shift applied to y (1024-byte row pitch).

- clock  in  1  clock; all logic on posedge clock.
- reset  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle fill request; honoured only in IDLE.
- abort  in  1  stop the fill after the in-flight write is accepted.
- base_addr  in  32  pixel buffer byte base address.
- color  in  16  RGB565 fill colour.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when a fill ends (completed or aborted).
- m_address  out  32  byte address of the current pixel.
- m_writedata  out  32  {color, color}.
- m_byteenable  out  4  4'b1100 if m_address[1], else 4'b0011.
- m_write  out  1  write request.
- m_waitrequest  in  1  Avalon stall.

## Operation
- States: IDLE, WRITE, DONE.
- IDLE:
  - busy=0, m_write=0.
  - On start=1: latch base_addr and color, clear x=0 and y=0, go to WRITE.
  - base_addr and color are not sampled after the start cycle.
- WRITE:
  - m_write=1.
  - m_address = base + (y << Y_SHIFT) + (x << X_SHIFT), with 32-bit modular sum.
  - A transfer is accepted in a cycle with m_write=1 and m_waitrequest=0.
  - On acceptance:
    - If x < WIDTH-1: x++.
    - Else: x=0 and y++.
    - If (x,y) = (WIDTH-1, HEIGHT-1), or the abort flag is set: go to DONE.
- abort:
  - Sampled every cycle in WRITE and held in a sticky flag that clears on entry to IDLE.
  - m_write, m_address and m_writedata must stay stable while m_waitrequest=1. Abort therefore never drops a stalled write.
  - The pixel in flight completes; no further pixels are issued.
  - abort in IDLE or DONE is ignored.
- DONE: done=1, busy=0, m_write=0 for exactly one cycle, then IDLE.
- start is ignored in WRITE and DONE, including start coincident with done. A new fill needs start in IDLE.
- Counters: x is $clog2(WIDTH) bits and y is $clog2(HEIGHT) bits. They never exceed WIDTH-1 / HEIGHT-1.

## Timing
- Reset values:
  - state=IDLE; busy=0, done=0, m_write=0.
  - m_address=0, m_writedata=0, m_byteenable=0.
- Reset mid-fill: the write is abandoned immediately and asynchronously. No done pulse is generated.
- start sampled at edge N → WRITE at N+1 with the first write at (0,0).
- Throughput: one pixel per cycle with waitrequest=0. An uncontended fill takes WIDTH*HEIGHT WRITE cycles plus one DONE cycle.
- Each waitrequest=1 cycle adds exactly one cycle of latency.
- All outputs are registered or decoded from registered state only. There is no combinational path from m_waitrequest to m_write.

## Test plan
- WIDTH=4, HEIGHT=3, base=0x0800_0000, color=0xF800, waitrequest=0 → 12 writes at 0x08000000, 02, 04, 06, 0x08000400 … 0x08000806.
  - byteenable alternates 0011/1100; writedata=0xF800F800.
  - done pulses exactly 13 cycles after the start edge.
- Same configuration, waitrequest high for 3 cycles on the 5th write → address 0x08000400 and data held stable for 4 cycles; done is delayed by 3 cycles; 12 writes total.
- abort asserted while the 2nd write is stalled → the 2nd write (0x08000002) completes, no 3rd write is issued, done pulses the next cycle, busy=0.
- start pulsed during WRITE with different base/color → ignored; all 12 writes use the original values. start in the done cycle → ignored; stays IDLE.
- Reset asserted mid-fill after 5 writes → m_write, busy and done go to 0 immediately. After release, start with base=0x0804_0000 → a fresh fill from (0,0) at 0x08040000.
- Defaults (320×240), base=0x0800_0000, random waitrequest → exactly 76800 accepted writes, no address repeated, last address 0x0803BE7E.
